// File: rtl/vga_display_driver.sv
// VGA raster timing generator with an internal eight-bar colour test pattern.
// Counters describe the current pixel; all port outputs are registered one clock behind them.
module vga_display_driver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int COLOR_W  = 4
) (
  input  logic               clk_60Mhz,
  input  logic               reset_,
  output logic               o_h_sync,
  output logic               o_v_sync,
  output logic [COLOR_W-1:0] o_r,
  output logic [COLOR_W-1:0] o_g,
  output logic [COLOR_W-1:0] o_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int SEG_W   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0]    H_MAX      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]    H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0]    H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]    H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]    V_MAX      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]    V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0]    V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]    V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SEG_W-1:0] SEG_MAX    = SEG_W'(BAR_W - 1);

  logic [HW-1:0]    h_cnt;
  logic [VW-1:0]    v_cnt;
  logic [SEG_W-1:0] seg_cnt;
  logic [2:0]       bar;

  logic       h_wrap;
  logic       v_wrap;
  logic       seg_wrap;
  logic       active;
  logic       h_sync_n;
  logic       v_sync_n;
  logic [2:0] c;

  always_comb begin
    h_wrap   = (h_cnt == H_MAX);
    v_wrap   = (v_cnt == V_MAX);
    seg_wrap = (seg_cnt == SEG_MAX);
    active   = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    h_sync_n = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
    v_sync_n = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
    c        = 3'd7 - bar;
  end

  always_ff @(posedge clk_60Mhz or posedge reset_) begin
    if (reset_) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      seg_cnt <= '0;
      bar     <= '0;
    end else begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
      // Segment counter replaces h_cnt / BAR_W; it restarts with every line.
      if (h_wrap) begin
        seg_cnt <= '0;
        bar     <= '0;
      end else if (seg_wrap) begin
        seg_cnt <= '0;
        bar     <= bar + 3'd1;
      end else begin
        seg_cnt <= seg_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_60Mhz or posedge reset_) begin
    if (reset_) begin
      o_h_sync <= 1'b1;
      o_v_sync <= 1'b1;
      o_r      <= '0;
      o_g      <= '0;
      o_b      <= '0;
    end else begin
      o_h_sync <= h_sync_n;
      o_v_sync <= v_sync_n;
      // c read as {G,R,B} yields white, yellow, cyan, green, magenta, red, blue, black.
      o_g      <= (active && c[2]) ? '1 : '0;
      o_r      <= (active && c[1]) ? '1 : '0;
      o_b      <= (active && c[0]) ? '1 : '0;
    end
  end

endmodule

// File: tb/tb_vga_display_driver.sv
// Directed bench: default-timing instance for line/colour checks, a shrunken-timing
// instance (24x13 raster) for frame and vertical-blanking checks.
module tb_vga_display_driver;

  logic       clk;
  logic       reset_;
  logic       hs, vs;
  logic [3:0] r, g, b;
  logic       hs_s, vs_s;
  logic [3:0] r_s, g_s, b_s;
  logic [11:0] rgb, rgb_s;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;

  assign rgb   = {r, g, b};
  assign rgb_s = {r_s, g_s, b_s};

  vga_display_driver dut (
    .clk_60Mhz(clk), .reset_(reset_),
    .o_h_sync(hs), .o_v_sync(vs), .o_r(r), .o_g(g), .o_b(b)
  );

  vga_display_driver #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .COLOR_W(4)
  ) dut_s (
    .clk_60Mhz(clk), .reset_(reset_),
    .o_h_sync(hs_s), .o_v_sync(vs_s), .o_r(r_s), .o_g(g_s), .o_b(b_s)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int   hs_falls, hs_first, hs_last, hs_run, hs_low, hs_low_rgb;
  int   vs_falls, vs_rises, vs_first, vs_last, vs_run, vs_low;
  int   blank_bad, vblank_bad, p, hp, vp;
  logic hs_prev, vs_prev;

  initial begin
    reset_ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_hs", 32'(hs), 32'd1);
      check("rst_vs", 32'(vs), 32'd1);
      check("rst_rgb", 32'(rgb), 32'h000);
    end

    reset_ = 1'b0;
    k = 0;
    hs_falls = 0; hs_first = 0; hs_last = 0; hs_run = 0; hs_low = 0; hs_low_rgb = 0;
    vs_falls = 0; vs_rises = 0; vs_first = 0; vs_last = 0; vs_run = 0; vs_low = 0;
    blank_bad = 0; vblank_bad = 0;
    hs_prev = 1'b1; vs_prev = 1'b1;

    for (int i = 0; i < 2400; i++) begin
      tick();
      if (!hs && hs_prev) begin
        hs_falls++;
        if (hs_falls == 1) hs_first = k;
        hs_last = k;
        hs_run = 0;
      end
      if (!hs) begin
        hs_run++;
        if (rgb != 12'h000) hs_low_rgb++;
      end
      if (hs && !hs_prev) hs_low = hs_run;
      hs_prev = hs;

      if (!vs_s && vs_prev) begin
        vs_falls++;
        if (vs_falls == 1) vs_first = k;
        vs_last = k;
        vs_run = 0;
      end
      if (!vs_s) vs_run++;
      if (vs_s && !vs_prev) begin
        vs_low = vs_run;
        vs_rises++;
      end
      vs_prev = vs_s;

      if (k == 1)   check("px0",   32'(rgb), 32'hFFF);
      if (k == 81)  check("px80",  32'(rgb), 32'hFF0);
      if (k == 161) check("px160", 32'(rgb), 32'h0FF);
      if (k == 241) check("px240", 32'(rgb), 32'h0F0);
      if (k == 321) check("px320", 32'(rgb), 32'hF0F);
      if (k == 401) check("px400", 32'(rgb), 32'hF00);
      if (k == 560) check("px559", 32'(rgb), 32'h00F);
      if (k == 561) check("px560", 32'(rgb), 32'h000);
      if (k == 640) check("px639", 32'(rgb), 32'h000);
      if (k >= 641 && k <= 800 && rgb != 12'h000) blank_bad++;

      if (k == 121) check("s_l5_px0",  32'(rgb_s), 32'hFFF);
      if (k == 134) check("s_l5_px13", 32'(rgb_s), 32'h00F);
      if (k == 136) check("s_l5_px15", 32'(rgb_s), 32'h000);
      p  = k - 1;
      hp = p % 24;
      vp = (p / 24) % 13;
      if ((vp >= 6 || hp >= 16) && rgb_s != 12'h000) vblank_bad++;
    end

    check("hs_first_fall", 32'(hs_first), 32'd657);
    check("hs_fall_count", 32'(hs_falls), 32'd3);
    check("hs_period2",    32'(hs_last - hs_first), 32'd1600);
    check("hs_low_len",    32'(hs_low), 32'd96);
    check("hs_low_rgb",    32'(hs_low_rgb), 32'd0);
    check("hblank_rgb",    32'(blank_bad), 32'd0);
    check("s_vs_first",    32'(vs_first), 32'd193);
    check("s_vs_falls",    32'(vs_falls), 32'd8);
    check("s_vs_period7",  32'(vs_last - vs_first), 32'd2184);
    check("s_vs_low_len",  32'(vs_low), 32'd48);
    check("s_vs_pulses",   32'(vs_rises), 32'd7);
    check("s_vblank_rgb",  32'(vblank_bad), 32'd0);

    while (k < 2701) tick();
    check("pre_rst_rgb",  32'(rgb), 32'h0F0);
    check("pre_rst_vs_s", 32'(vs_s), 32'd0);
    #10;
    reset_ = 1'b1;
    #1;
    check("async_rgb",  32'(rgb), 32'h000);
    check("async_vs_s", 32'(vs_s), 32'd1);
    check("async_hs",   32'(hs), 32'd1);
    tick();
    check("hold_rgb",   32'(rgb), 32'h000);
    tick();
    check("hold_vs_s",  32'(vs_s), 32'd1);

    reset_ = 1'b0;
    k = 0;
    hs_first = 0; vs_first = 0;
    hs_prev = 1'b1; vs_prev = 1'b1;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (k == 1) check("rst2_px0", 32'(rgb), 32'hFFF);
      if (!hs && hs_prev && hs_first == 0) hs_first = k;
      if (!vs_s && vs_prev && vs_first == 0) vs_first = k;
      hs_prev = hs;
      vs_prev = vs_s;
    end
    check("rst2_hs_fall",   32'(hs_first), 32'd657);
    check("rst2_s_vs_fall", 32'(vs_first), 32'd193);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
